spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, RX FIFO entries; power of two, 2 to 16.
REQ-002 Parameter TX_IDLE, default 8'hFF, byte shifted out when no TX byte is pending.
REQ-003 clk  in  1  system clock; one clock domain.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 address_in  in  32  bus address; bits [3:2] select the register.
REQ-006 sel_in  in  1  bus select for this peripheral.
REQ-007 read_in  in  1  bus read strobe.
REQ-008 read_value_out  out  32  read data; 0 when sel_in=0, so the read bus can be ORed.
REQ-009 write_mask_in  in  4  byte-lane write enables.
REQ-010 write_value_in  in  32  write data.
REQ-011 ready_out  out  1  access complete.
REQ-012 spi_sclk_in  in  1  external master SPI clock, asynchronous.
REQ-013 spi_mosi_in  in  1  master-out serial data.
REQ-014 spi_cs_n_in  in  1  chip select, active-low.
REQ-015 spi_dc_in  in  1  data/command flag (1 = data).
REQ-016 spi_miso_out  out  1  target-out serial data.
REQ-017 spi_miso_en  out  1  MISO pad output enable.

Function
REQ-018 spi_sclk_in, spi_mosi_in, spi_cs_n_in and spi_dc_in SHALL each pass through a 2-flop synchronizer before use.
REQ-019 SPI mode 0, MSB first: MOSI SHALL be sampled on a synchronized SCLK rising edge; MISO SHALL change on a falling edge.
REQ-020 Supported SCLK frequency SHALL be at most clk/8.
REQ-021 FSM states SHALL be IDLE (CS high) and ACTIVE (CS low).
REQ-022 IDLE->ACTIVE on synchronized CS falling: bit counter cleared, TX shift register loaded (TX byte if pending, else TX_IDLE), tx_pending cleared.
REQ-023 ACTIVE->IDLE on synchronized CS rising: partial byte discarded, bit counter cleared, no FIFO push.
REQ-024 On the 8th rising edge the block SHALL push {dc, byte} into the RX FIFO in the following clk cycle; dc is sampled at that edge.
REQ-025 After each completed byte the bit counter SHALL wrap to 0 and the TX shift register SHALL reload per REQ-022.
REQ-026 spi_miso_en SHALL equal synchronized CS active; spi_miso_out SHALL be the TX shift MSB, or 0 when not enabled.
REQ-027 Push into a full FIFO SHALL drop the byte and set sticky overrun.
REQ-028 If a pop and a push occur in the same cycle on a full FIFO, both SHALL complete with no overrun; the count is unchanged.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits wide.
REQ-030 ready_out SHALL equal sel_in; every access is zero-wait, single cycle.
REQ-031 Offset 0x0 DATA read: returns {23'b0, dc, byte} of the FIFO head and pops one entry per cycle with sel_in & read_in; an empty FIFO returns 0 and does not pop.
REQ-032 Offset 0x0 DATA write with write_mask_in[0] SHALL load the TX byte and set tx_pending; a new write overwrites an unconsumed byte.
REQ-033 Offset 0x4 STATUS read bits: [0] rx_valid, [1] rx_full, [2] overrun, [3] cs_active, [4] tx_pending, [8+:5] count; other bits 0.
REQ-034 STATUS write with write_mask_in[0] and bit 2 set SHALL clear overrun; a same-cycle overrun event takes priority.
REQ-035 Offsets 0x8 and 0xC SHALL read 0; writes to them are ignored.

Reset
REQ-036 With reset_n low: FSM IDLE, FIFO empty, overrun=0, tx_pending=0, TX byte=0, synchronizers at idle levels (sclk=0, cs_n=1), spi_miso_out=0, spi_miso_en=0, read_value_out=0.
REQ-037 Reset assertion mid-byte SHALL abort immediately; no partial byte is ever pushed.

Verification
REQ-038 CS low, master sends 0xA5 with dc=1, CS high -> STATUS=0x0101; DATA read=0x1A5; STATUS then 0x0000.
REQ-039 Write DATA=0x3C, then master clocks 2 bytes 0x11,0x22 -> MISO yields 0x3C then 0xFF; FIFO holds 0x111 then 0x122 (dc=1).
REQ-040 FIFO_DEPTH=4, master sends 5 bytes without pops -> count=4, overrun=1, first 4 bytes intact; STATUS write 0x4 clears overrun.
REQ-041 CS raised after 5 bits, then a full byte 0x5A -> only 0x5A is received, count=1.
REQ-042 FIFO full, DATA pop in the same cycle as a byte push -> count stays 4, overrun=0, order preserved.
REQ-043 reset_n pulsed low mid-byte -> all REQ-036 values hold; the next full byte is received correctly.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target with a memory-mapped register front end.
// Serial inputs are synchronized into clk; SCLK edges are detected in the
// clk domain, received bytes are queued with their D/C flag in an RX FIFO,
// and a single TX byte register feeds MISO.
module spi_target #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] TX_IDLE    = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    input  logic        spi_sclk_in,
    input  logic        spi_mosi_in,
    input  logic        spi_cs_n_in,
    input  logic        spi_dc_in,
    output logic        spi_miso_out,
    output logic        spi_miso_en
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic [1:0]    r_sclk_sync, r_mosi_sync, r_cs_sync, r_dc_sync;
    logic          r_sclk_prev;
    state_t        r_state, w_state_nxt;
    logic          w_start, w_stop, w_active_bit;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_rx_sh, r_tx_sh, r_tx_byte;
    logic          r_tx_pending, r_push_vld, r_overrun;
    logic [8:0]    r_push_data;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   w_rdata;

    wire       w_sclk      = r_sclk_sync[1];
    wire       w_cs_n      = r_cs_sync[1];
    wire       w_rise      = w_sclk & ~r_sclk_prev;
    wire       w_fall      = ~w_sclk & r_sclk_prev;
    wire [1:0] w_reg       = address_in[3:2];
    wire       w_wr        = sel_in & ~read_in & write_mask_in[0];
    wire       w_empty     = (r_count == '0);
    wire       w_full      = (r_count == FULL_CNT);
    wire       w_pop       = sel_in & read_in & (w_reg == 2'd0) & ~w_empty;
    wire       w_push_ok   = r_push_vld & (~w_full | w_pop);
    wire       w_byte_done = w_active_bit & w_rise & (r_bit_cnt == 3'd7);
    // A new TX byte is taken at transfer start and at every byte boundary.
    wire       w_tx_load   = w_start | w_byte_done;

    wire w_unused = ^{address_in[31:4], address_in[1:0], write_mask_in[3:1],
                      write_value_in[31:8]};

    // Two-flop synchronizers, reset to bus-idle levels, plus SCLK history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_dc_sync   <= 2'b00;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_sclk_in};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi_in};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_n_in};
            r_dc_sync   <= {r_dc_sync[0], spi_dc_in};
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: follows synchronized chip select.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_cs_n) w_state_nxt = ACTIVE;
            ACTIVE:  if (w_cs_n)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: transfer start/stop strobes and bit-accept qualifier.
    always_comb begin
        w_start      = (r_state == IDLE) && !w_cs_n;
        w_stop       = (r_state == ACTIVE) && w_cs_n;
        w_active_bit = (r_state == ACTIVE) && !w_cs_n;
    end

    // Shift engine: sample MOSI on rise, shift MISO on fall. The fall right
    // after a byte boundary is skipped so the freshly loaded MSB stays put.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt   <= '0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_push_vld  <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push_vld <= w_byte_done;
            if (w_byte_done)
                r_push_data <= {r_dc_sync[1], r_rx_sh[6:0], r_mosi_sync[1]};
            if (w_tx_load)
                r_tx_sh <= r_tx_pending ? r_tx_byte : TX_IDLE;
            else if (w_active_bit && w_fall && r_bit_cnt != 3'd0)
                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            if (w_start || w_stop) begin
                r_bit_cnt <= '0;
            end else if (w_active_bit && w_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_rx_sh   <= {r_rx_sh[6:0], r_mosi_sync[1]};
            end
        end
    end

    // TX byte register; a fresh write beats a same-cycle consume.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_byte    <= '0;
            r_tx_pending <= 1'b0;
        end else if (w_wr && w_reg == 2'd0) begin
            r_tx_byte    <= write_value_in[7:0];
            r_tx_pending <= 1'b1;
        end else if (w_tx_load) begin
            r_tx_pending <= 1'b0;
        end
    end

    // RX FIFO storage; no reset needed, occupancy lives in r_count.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_push_data;
    end

    // RX FIFO pointers, count and sticky overrun (overrun beats clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
            if (r_push_vld && w_full && !w_pop)
                r_overrun <= 1'b1;
            else if (w_wr && w_reg == 2'd1 && write_value_in[2])
                r_overrun <= 1'b0;
        end
    end

    // Read mux; zero when not selected so several peripherals can be ORed.
    always_comb begin
        w_rdata = '0;
        if (sel_in) begin
            case (w_reg)
                2'd0: if (!w_empty) w_rdata[8:0] = r_mem[r_rd_ptr];
                2'd1: begin
                    w_rdata[0]    = ~w_empty;
                    w_rdata[1]    = w_full;
                    w_rdata[2]    = r_overrun;
                    w_rdata[3]    = ~w_cs_n;
                    w_rdata[4]    = r_tx_pending;
                    w_rdata[12:8] = 5'(r_count);
                end
                default: w_rdata = '0;
            endcase
        end
    end

    assign read_value_out = w_rdata;
    assign ready_out      = sel_in;
    assign spi_miso_en    = ~w_cs_n;
    assign spi_miso_out   = ~w_cs_n & r_tx_sh[7];
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bus-functional SPI master plus register driver,
// a queue-based reference model and a read-data scoreboard monitor.
module tb_spi_target;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address_in = '0;
    logic        sel_in = 1'b0, read_in = 1'b0;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in = '0;
    logic [31:0] write_value_in = '0;
    logic        ready_out;
    logic        spi_sclk_in = 1'b0, spi_mosi_in = 1'b0;
    logic        spi_cs_n_in = 1'b1, spi_dc_in = 1'b0;
    logic        spi_miso_out, spi_miso_en;

    always #5 clk = ~clk;

    spi_target #(.FIFO_DEPTH(DEPTH), .TX_IDLE(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .address_in(address_in), .sel_in(sel_in),
        .read_in(read_in), .read_value_out(read_value_out),
        .write_mask_in(write_mask_in), .write_value_in(write_value_in),
        .ready_out(ready_out), .spi_sclk_in(spi_sclk_in), .spi_mosi_in(spi_mosi_in),
        .spi_cs_n_in(spi_cs_n_in), .spi_dc_in(spi_dc_in),
        .spi_miso_out(spi_miso_out), .spi_miso_en(spi_miso_en));

    int n_chk = 0, n_pass = 0;
    logic [31:0] exp_q[$];

    // reference model state
    logic [8:0] m_fifo[$];
    bit         m_ovr = 0, m_txpend = 0, m_cs = 0;
    logic [7:0] m_txbyte = '0, m_miso = 8'hFF;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_status();
        return {19'b0, 5'(m_fifo.size()), 3'b0, m_txpend, m_cs, m_ovr,
                m_fifo.size() == DEPTH, m_fifo.size() != 0};
    endfunction

    function automatic logic [7:0] m_load();
        logic [7:0] v;
        v = m_txpend ? m_txbyte : 8'hFF;
        m_txpend = 0;
        return v;
    endfunction

    task automatic bus_read(input logic [3:0] off);
        logic [31:0] e;
        e = '0;
        if (off == 4'h0 && m_fifo.size() != 0) e = {23'b0, m_fifo.pop_front()};
        else if (off == 4'h4) e = m_status();
        exp_q.push_back(e);
        address_in = {28'b0, off};
        sel_in = 1'b1;
        read_in = 1'b1;
        cyc(1);
        sel_in = 1'b0;
        read_in = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
        if (off == 4'h0) begin
            m_txbyte = data[7:0];
            m_txpend = 1;
        end else if (off == 4'h4 && data[2]) begin
            m_ovr = 0;
        end
        address_in = {28'b0, off};
        write_value_in = data;
        write_mask_in = 4'h1;
        sel_in = 1'b1;
        cyc(1);
        sel_in = 1'b0;
        write_mask_in = '0;
    endtask

    task automatic cs_low();
        spi_cs_n_in = 1'b0;
        cyc(6);
        m_cs = 1;
        m_miso = m_load();
    endtask

    task automatic cs_high();
        spi_cs_n_in = 1'b1;
        cyc(6);
        m_cs = 0;
    endtask

    // Master: SCLK half period of 5 clk. pop_sync lands a DATA pop in the
    // exact clk cycle the DUT pushes the completed byte.
    task automatic spi_byte(input logic [7:0] b, input bit dc, input int nbits, input bit pop_sync);
        logic [7:0] got;
        got = '0;
        spi_dc_in = dc;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_in = b[7-i];
            cyc(5);
            got[7-i] = spi_miso_out;
            spi_sclk_in = 1'b1;
            if (pop_sync && i == 7) begin
                cyc(3);
                bus_read(4'h0);
                cyc(1);
            end else begin
                cyc(5);
            end
            spi_sclk_in = 1'b0;
        end
        if (nbits == 8) begin
            check("miso_byte", {24'b0, got}, {24'b0, m_miso});
            m_miso = m_load();
            if (m_fifo.size() < DEPTH) m_fifo.push_back({dc, b});
            else m_ovr = 1;
        end
    endtask

    // Scoreboard monitor: compares every presented read against the queue.
    always @(negedge clk) begin
        if (sel_in && read_in) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: got %h expected none", read_value_out);
            end else begin
                check("rdata", read_value_out, exp_q.pop_front());
            end
            check("ready", {31'b0, ready_out}, 32'd1);
        end else if (!sel_in) begin
            check("rdata_idle", read_value_out, 32'd0);
        end
    end

    initial begin
        int nb;
        // reset state
        cyc(3);
        check("rst_miso", {31'b0, spi_miso_out}, 32'd0);
        check("rst_miso_en", {31'b0, spi_miso_en}, 32'd0);
        reset_n = 1'b1;
        cyc(2);
        bus_read(4'h4);

        // single byte with dc=1
        cs_low();
        spi_byte(8'hA5, 1'b1, 8, 1'b0);
        cs_high();
        bus_read(4'h4);
        bus_read(4'h0);
        bus_read(4'h4);

        // TX byte then idle fill
        bus_write(4'h0, 32'h0000_003C);
        bus_read(4'h4);
        cs_low();
        bus_read(4'h4);
        spi_byte(8'h11, 1'b1, 8, 1'b0);
        spi_byte(8'h22, 1'b1, 8, 1'b0);
        cs_high();
        bus_read(4'h0);
        bus_read(4'h0);
        bus_read(4'h0);

        // overrun on 5th byte, then clear
        cs_low();
        for (int i = 0; i < 5; i++) spi_byte(8'($urandom), 1'($urandom), 8, 1'b0);
        cs_high();
        bus_read(4'h4);
        bus_write(4'h4, 32'h4);
        bus_read(4'h4);
        for (int i = 0; i < 4; i++) bus_read(4'h0);
        bus_read(4'h4);

        // aborted partial byte then a full byte
        cs_low();
        spi_byte(8'($urandom), 1'b1, 5, 1'b0);
        cs_high();
        cs_low();
        spi_byte(8'h5A, 1'b0, 8, 1'b0);
        cs_high();
        bus_read(4'h4);
        bus_read(4'h0);

        // full FIFO, pop coincident with push
        cs_low();
        for (int i = 0; i < 4; i++) spi_byte(8'($urandom), 1'($urandom), 8, 1'b0);
        spi_byte(8'($urandom), 1'b1, 8, 1'b1);
        cs_high();
        bus_read(4'h4);
        for (int i = 0; i < 4; i++) bus_read(4'h0);

        // unused offsets
        bus_write(4'h8, 32'hFFFF_FFFF);
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'h8);
        bus_read(4'hC);
        bus_read(4'h4);

        // reset mid-byte
        cs_low();
        spi_byte(8'($urandom), 1'b1, 4, 1'b0);
        reset_n = 1'b0;
        cyc(2);
        check("rst_mid_miso", {31'b0, spi_miso_out}, 32'd0);
        check("rst_mid_miso_en", {31'b0, spi_miso_en}, 32'd0);
        spi_cs_n_in = 1'b1;
        m_fifo.delete();
        m_ovr = 0; m_txpend = 0; m_txbyte = '0; m_cs = 0;
        cyc(1);
        reset_n = 1'b1;
        cyc(4);
        bus_read(4'h4);
        cs_low();
        spi_byte(8'hC3, 1'b1, 8, 1'b0);
        cs_high();
        bus_read(4'h4);
        bus_read(4'h0);

        // randomized transfers
        for (int it = 0; it < 15; it++) begin
            if ($urandom_range(1, 0) == 1) bus_write(4'h0, $urandom);
            cs_low();
            nb = $urandom_range(3, 1);
            for (int k = 0; k < nb; k++) spi_byte(8'($urandom), 1'($urandom), 8, 1'b0);
            cs_high();
            bus_read(4'h4);
            while (m_fifo.size() != 0) bus_read(4'h0);
            bus_read(4'h0);
        end

        cyc(3);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d reads left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
